// File: rtl/issue_scoreboard.sv
// Issue controller: dispatches one decoded instruction per cycle to a single unit
// and tracks register destinations still pending in LSU, div and the mul pipe.
module issue_scoreboard #(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_valid_i,
    output logic        fetch_accept_o,
    input  logic [31:0] opcode_i,
    input  logic        dec_exec_i,
    input  logic        dec_lsu_i,
    input  logic        dec_branch_i,
    input  logic        dec_mul_i,
    input  logic        dec_div_i,
    input  logic        dec_csr_i,
    input  logic        dec_rd_valid_i,
    input  logic        squash_i,
    input  logic        lsu_accept_i,
    input  logic        lsu_complete_i,
    input  logic        div_complete_i,
    output logic        issue_exec_o,
    output logic        issue_lsu_o,
    output logic        issue_branch_o,
    output logic        issue_mul_o,
    output logic        issue_div_o,
    output logic        issue_csr_o,
    output logic [4:0]  issue_rd_o,
    output logic        busy_o
);
    localparam int unsigned REG_W = 5;
    localparam int unsigned NREG  = 32;

    logic                   r_lsu_valid;
    logic                   r_lsu_wb;
    logic [REG_W-1:0]       r_lsu_rd;
    logic                   r_div_valid;
    logic [REG_W-1:0]       r_div_rd;
    logic [MUL_LATENCY-1:0] r_mul_valid;
    logic [REG_W-1:0]       r_mul_rd [MUL_LATENCY];

    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    logic [REG_W-1:0] w_rd_eff;
    logic [NREG-1:0]  w_busy_mask;
    logic             w_busy;
    logic             w_hazard;
    logic             w_stall;
    logic             w_go;
    logic             w_sel_csr;
    logic             w_sel_lsu;
    logic             w_sel_div;
    logic             w_sel_mul;
    logic             w_sel_branch;
    logic             w_sel_exec;
    logic             w_any_issue;
    logic             w_unused_opcode;

    assign w_rd     = opcode_i[11:7];
    assign w_rs1    = opcode_i[19:15];
    assign w_rs2    = opcode_i[24:20];
    assign w_rd_eff = dec_rd_valid_i ? w_rd : '0;
    assign w_unused_opcode = ^{opcode_i[31:25], opcode_i[14:12], opcode_i[6:0]};

    // Registers with a write still in flight; loads without writeback are not tracked.
    always_comb begin : busy_mask
        w_busy_mask = '0;
        if (r_lsu_valid && r_lsu_wb) w_busy_mask[r_lsu_rd] = 1'b1;
        if (r_div_valid)             w_busy_mask[r_div_rd] = 1'b1;
        for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            if (r_mul_valid[i]) w_busy_mask[r_mul_rd[i]] = 1'b1;
        end
        w_busy_mask[0] = 1'b0;
    end

    assign w_busy   = r_lsu_valid | r_div_valid | (|r_mul_valid);
    assign w_hazard = w_busy_mask[w_rs1] | w_busy_mask[w_rs2]
                    | (dec_rd_valid_i & w_busy_mask[w_rd]);
    assign w_stall  = w_hazard
                    | (dec_lsu_i & (r_lsu_valid | ~lsu_accept_i))
                    | (dec_div_i & r_div_valid)
                    | (dec_csr_i & w_busy);
    assign w_go     = ~rst_i & fetch_valid_i & ~squash_i & ~w_stall;

    // Fixed priority csr > lsu > div > mul > branch > exec keeps dispatch one-hot.
    assign w_sel_csr    = w_go & dec_csr_i;
    assign w_sel_lsu    = w_go & dec_lsu_i & ~dec_csr_i;
    assign w_sel_div    = w_go & dec_div_i & ~dec_csr_i & ~dec_lsu_i;
    assign w_sel_mul    = w_go & dec_mul_i & ~dec_csr_i & ~dec_lsu_i & ~dec_div_i;
    assign w_sel_branch = w_go & dec_branch_i & ~dec_csr_i & ~dec_lsu_i & ~dec_div_i
                        & ~dec_mul_i;
    assign w_sel_exec   = w_go & dec_exec_i & ~dec_csr_i & ~dec_lsu_i & ~dec_div_i
                        & ~dec_mul_i & ~dec_branch_i;
    assign w_any_issue  = w_sel_csr | w_sel_lsu | w_sel_div | w_sel_mul
                        | w_sel_branch | w_sel_exec;

    assign fetch_accept_o = ~rst_i & fetch_valid_i & (squash_i | ~w_stall);
    assign issue_csr_o    = w_sel_csr;
    assign issue_lsu_o    = w_sel_lsu;
    assign issue_div_o    = w_sel_div;
    assign issue_mul_o    = w_sel_mul;
    assign issue_branch_o = w_sel_branch;
    assign issue_exec_o   = w_sel_exec;
    assign issue_rd_o     = w_any_issue ? w_rd_eff : '0;
    assign busy_o         = w_busy;

    // A new issue takes precedence over a same-cycle completion of the same unit.
    always_ff @(posedge clk_i) begin : scoreboard_regs
        if (rst_i) begin
            r_lsu_valid <= 1'b0;
            r_lsu_wb    <= 1'b0;
            r_lsu_rd    <= '0;
            r_div_valid <= 1'b0;
            r_div_rd    <= '0;
            r_mul_valid <= '0;
            for (int unsigned i = 0; i < MUL_LATENCY; i++) r_mul_rd[i] <= '0;
        end else begin
            if (w_sel_lsu) begin
                r_lsu_valid <= 1'b1;
                r_lsu_wb    <= dec_rd_valid_i;
                r_lsu_rd    <= w_rd;
            end else if (lsu_complete_i) begin
                r_lsu_valid <= 1'b0;
            end
            if (w_sel_div) begin
                r_div_valid <= 1'b1;
                r_div_rd    <= w_rd_eff;
            end else if (div_complete_i) begin
                r_div_valid <= 1'b0;
            end
            r_mul_valid[0] <= w_sel_mul;
            r_mul_rd[0]    <= w_rd_eff;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                r_mul_valid[i] <= r_mul_valid[i-1];
                r_mul_rd[i]    <= r_mul_rd[i-1];
            end
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: expected dispatches are queued with
// their cycle when stimulus is driven and popped as the DUT issues.
module tb_issue_scoreboard;
    localparam int MUL_LAT = 2;

    localparam logic [2:0] U_NONE = 3'd0;
    localparam logic [2:0] U_EXEC = 3'd1;
    localparam logic [2:0] U_BR   = 3'd2;
    localparam logic [2:0] U_MUL  = 3'd3;
    localparam logic [2:0] U_DIV  = 3'd4;
    localparam logic [2:0] U_LSU  = 3'd5;
    localparam logic [2:0] U_CSR  = 3'd6;
    localparam logic [2:0] U_BAD  = 3'd7;

    // dec mask order: {csr, lsu, div, mul, branch, exec}
    localparam logic [5:0] D_EXEC = 6'b000001;
    localparam logic [5:0] D_BR   = 6'b000010;
    localparam logic [5:0] D_MUL  = 6'b000100;
    localparam logic [5:0] D_DIV  = 6'b001000;
    localparam logic [5:0] D_LSU  = 6'b010000;
    localparam logic [5:0] D_CSR  = 6'b100000;

    typedef struct {
        int         cyc;
        logic [2:0] unit;
        logic [4:0] rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        fetch_valid_i;
    logic        fetch_accept_o;
    logic [31:0] opcode_i;
    logic        dec_exec_i, dec_lsu_i, dec_branch_i, dec_mul_i, dec_div_i, dec_csr_i;
    logic        dec_rd_valid_i;
    logic        squash_i;
    logic        lsu_accept_i;
    logic        lsu_complete_i;
    logic        div_complete_i;
    logic        issue_exec_o, issue_lsu_o, issue_branch_o, issue_mul_o, issue_div_o, issue_csr_o;
    logic [4:0]  issue_rd_o;
    logic        busy_o;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    exp_t        e;
    logic [2:0]  ex_u;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    issue_scoreboard #(.MUL_LATENCY(MUL_LAT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_accept_o (fetch_accept_o),
        .opcode_i       (opcode_i),
        .dec_exec_i     (dec_exec_i),
        .dec_lsu_i      (dec_lsu_i),
        .dec_branch_i   (dec_branch_i),
        .dec_mul_i      (dec_mul_i),
        .dec_div_i      (dec_div_i),
        .dec_csr_i      (dec_csr_i),
        .dec_rd_valid_i (dec_rd_valid_i),
        .squash_i       (squash_i),
        .lsu_accept_i   (lsu_accept_i),
        .lsu_complete_i (lsu_complete_i),
        .div_complete_i (div_complete_i),
        .issue_exec_o   (issue_exec_o),
        .issue_lsu_o    (issue_lsu_o),
        .issue_branch_o (issue_branch_o),
        .issue_mul_o    (issue_mul_o),
        .issue_div_o    (issue_div_o),
        .issue_csr_o    (issue_csr_o),
        .issue_rd_o     (issue_rd_o),
        .busy_o         (busy_o)
    );

    function automatic logic [2:0] obs_unit();
        logic [5:0] v;
        v = {issue_csr_o, issue_lsu_o, issue_div_o, issue_mul_o, issue_branch_o, issue_exec_o};
        case (v)
            6'b000000: return U_NONE;
            D_EXEC:    return U_EXEC;
            D_BR:      return U_BR;
            D_MUL:     return U_MUL;
            D_DIV:     return U_DIV;
            D_LSU:     return U_LSU;
            D_CSR:     return U_CSR;
            default:   return U_BAD;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [5:0] dec, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic rdv);
        fetch_valid_i = v;
        {dec_csr_i, dec_lsu_i, dec_div_i, dec_mul_i, dec_branch_i, dec_exec_i} = dec;
        opcode_i = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
        dec_rd_valid_i = rdv;
    endtask

    task automatic side_defaults();
        rst_i = 1'b0;
        squash_i = 1'b0;
        lsu_accept_i = 1'b1;
        lsu_complete_i = 1'b0;
        div_complete_i = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    task automatic test_reset();
        side_defaults();
        rst_i = 1'b1;
        drive(1'b1, D_EXEC, 5'd1, 5'd0, 5'd0, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (fetch_accept_o !== 1'b0) begin
            errors++; $display("FAIL reset.accept got=%b want=0", fetch_accept_o);
        end
        checks++;
        if (obs_unit() !== U_NONE || issue_rd_o !== 5'd0) begin
            errors++; $display("FAIL reset.issue got unit=%0d rd=%0d want unit=0 rd=0", obs_unit(), issue_rd_o);
        end
        @(posedge clk); #1;
        side_defaults();
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset.busy got=%b want=0", busy_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_exec_stream();
        for (int k = 0; k < 6; k++) begin
            side_defaults();
            drive(1'b1, D_EXEC, 5'(k + 1), 5'd0, 5'd0, 1'b1);
            exp_q.push_back('{k, U_EXEC, 5'(k + 1)});
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL exec_stream.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            checks++;
            if (fetch_accept_o !== 1'b1) begin
                errors++; $display("FAIL exec_stream.accept k=%0d got=%b want=1", k, fetch_accept_o);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL exec_stream.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_mul_dep();
        for (int k = 0; k < MUL_LAT + 4; k++) begin
            side_defaults();
            if (k == 0) begin
                drive(1'b1, D_MUL, 5'd5, 5'd1, 5'd2, 1'b1);
                exp_q.push_back('{0, U_MUL, 5'd5});
            end else if (k <= MUL_LAT + 1) begin
                drive(1'b1, D_EXEC, 5'd6, 5'd5, 5'd1, 1'b1);
                if (k == 1) exp_q.push_back('{MUL_LAT + 1, U_EXEC, 5'd6});
            end
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL mul_dep.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k >= 1 && k <= MUL_LAT + 1) begin
                checks++;
                if (busy_o !== (k <= MUL_LAT) || fetch_accept_o !== (k > MUL_LAT)) begin
                    errors++; $display("FAIL mul_dep.busy_accept k=%0d got busy=%b accept=%b want busy=%b accept=%b", k, busy_o, fetch_accept_o, (k <= MUL_LAT), (k > MUL_LAT));
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL mul_dep.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < MUL_LAT + 4; k++) begin
            side_defaults();
            if (k < 3) begin
                drive(1'b1, D_MUL, 5'(10 + k), 5'd0, 5'd0, 1'b1);
                exp_q.push_back('{k, U_MUL, 5'(10 + k)});
            end else if (k == 3) begin
                drive(1'b1, D_EXEC, 5'd14, 5'd0, 5'd0, 1'b1);
                exp_q.push_back('{3, U_EXEC, 5'd14});
            end
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL back_to_back.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k == 3 || k == MUL_LAT + 3) begin
                checks++;
                if (busy_o !== (k == 3)) begin
                    errors++; $display("FAIL back_to_back.busy k=%0d got=%b want=%b", k, busy_o, (k == 3));
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL back_to_back.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_lsu();
        for (int k = 0; k < 16; k++) begin
            side_defaults();
            case (k)
                0: begin
                    drive(1'b1, D_LSU, 5'd7, 5'd1, 5'd0, 1'b1);
                    exp_q.push_back('{0, U_LSU, 5'd7});
                end
                1, 2, 3, 4, 5: begin
                    drive(1'b1, D_EXEC, 5'd8, 5'd7, 5'd0, 1'b1);
                    if (k == 1) exp_q.push_back('{5, U_EXEC, 5'd8});
                    if (k == 4) lsu_complete_i = 1'b1;
                end
                7, 8: begin
                    drive(1'b1, D_LSU, 5'd22, 5'd0, 5'd0, 1'b1);
                    if (k == 7) begin lsu_accept_i = 1'b0; exp_q.push_back('{8, U_LSU, 5'd22}); end
                end
                9, 10, 11, 12: begin
                    drive(1'b1, D_LSU, 5'd23, 5'd0, 5'd0, 1'b1);
                    if (k == 9) exp_q.push_back('{12, U_LSU, 5'd23});
                    if (k >= 11) lsu_complete_i = 1'b1;
                end
                14: lsu_complete_i = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL lsu.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k == 4 || k == 5 || k == 13 || k == 15) begin
                checks++;
                if (busy_o !== (k == 4 || k == 13)) begin
                    errors++; $display("FAIL lsu.busy k=%0d got=%b want=%b", k, busy_o, (k == 4 || k == 13));
                end
            end
            if (k == 7 || k == 11) begin
                checks++;
                if (fetch_accept_o !== 1'b0) begin
                    errors++; $display("FAIL lsu.accept k=%0d got=%b want=0", k, fetch_accept_o);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL lsu.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_csr_div();
        for (int k = 0; k < 6; k++) begin
            side_defaults();
            if (k == 0) begin
                drive(1'b1, D_DIV, 5'd9, 5'd1, 5'd2, 1'b1);
                exp_q.push_back('{0, U_DIV, 5'd9});
            end else if (k <= 4) begin
                drive(1'b1, D_CSR, 5'd3, 5'd4, 5'd0, 1'b1);
                if (k == 1) exp_q.push_back('{4, U_CSR, 5'd3});
                if (k == 3) div_complete_i = 1'b1;
            end
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL csr_div.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (busy_o !== (k == 3) || fetch_accept_o !== (k == 4)) begin
                    errors++; $display("FAIL csr_div.busy_accept k=%0d got busy=%b accept=%b want busy=%b accept=%b", k, busy_o, fetch_accept_o, (k == 3), (k == 4));
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL csr_div.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 7; k++) begin
            side_defaults();
            case (k)
                0: begin drive(1'b1, D_CSR | D_LSU | D_EXEC, 5'd1, 5'd0, 5'd0, 1'b1); exp_q.push_back('{0, U_CSR, 5'd1}); end
                1: begin drive(1'b1, D_LSU | D_MUL | D_EXEC, 5'd2, 5'd0, 5'd0, 1'b1); exp_q.push_back('{1, U_LSU, 5'd2}); end
                2: begin drive(1'b1, D_DIV | D_MUL | D_BR, 5'd3, 5'd0, 5'd0, 1'b1); exp_q.push_back('{2, U_DIV, 5'd3}); end
                3: begin drive(1'b1, D_MUL | D_BR | D_EXEC, 5'd4, 5'd0, 5'd0, 1'b1); exp_q.push_back('{3, U_MUL, 5'd4}); end
                4: begin drive(1'b1, D_BR | D_EXEC, 5'd13, 5'd0, 5'd0, 1'b0); exp_q.push_back('{4, U_BR, 5'd0}); end
                5: begin
                    drive(1'b1, 6'd0, 5'd15, 5'd0, 5'd0, 1'b1);
                    lsu_complete_i = 1'b1;
                    div_complete_i = 1'b1;
                end
                default: ;
            endcase
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL priority.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k == 5) begin
                checks++;
                if (fetch_accept_o !== 1'b1) begin
                    errors++; $display("FAIL priority.drop_accept got=%b want=1", fetch_accept_o);
                end
            end
            if (k == 6) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++; $display("FAIL priority.busy got=%b want=0", busy_o);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL priority.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_squash();
        for (int k = 0; k < 6; k++) begin
            side_defaults();
            case (k)
                0: begin drive(1'b1, D_LSU, 5'd7, 5'd0, 5'd0, 1'b1); exp_q.push_back('{0, U_LSU, 5'd7}); end
                1: begin drive(1'b1, D_LSU, 5'd24, 5'd0, 5'd0, 1'b1); squash_i = 1'b1; end
                2, 3, 4: begin
                    drive(1'b1, D_EXEC, 5'd25, 5'd7, 5'd0, 1'b1);
                    if (k == 2) exp_q.push_back('{4, U_EXEC, 5'd25});
                    if (k == 3) lsu_complete_i = 1'b1;
                end
                default: ;
            endcase
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL squash.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (fetch_accept_o !== (k == 1) || busy_o !== 1'b1) begin
                    errors++; $display("FAIL squash.accept_busy k=%0d got accept=%b busy=%b want accept=%b busy=1", k, fetch_accept_o, busy_o, (k == 1));
                end
            end
            if (k == 5) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++; $display("FAIL squash.busy got=%b want=0", busy_o);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL squash.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 6; k++) begin
            side_defaults();
            case (k)
                0: begin drive(1'b1, D_MUL, 5'd5, 5'd0, 5'd0, 1'b1); exp_q.push_back('{0, U_MUL, 5'd5}); end
                1: begin drive(1'b1, D_LSU, 5'd7, 5'd0, 5'd0, 1'b1); exp_q.push_back('{1, U_LSU, 5'd7}); end
                2: begin rst_i = 1'b1; drive(1'b1, D_EXEC, 5'd6, 5'd5, 5'd7, 1'b1); end
                3: begin drive(1'b1, D_EXEC, 5'd6, 5'd5, 5'd7, 1'b1); exp_q.push_back('{3, U_EXEC, 5'd6}); end
                4: lsu_complete_i = 1'b1;
                default: ;
            endcase
            @(negedge clk);
            ex_u = U_NONE; ex_rd = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc == k) begin e = exp_q.pop_front(); ex_u = e.unit; ex_rd = e.rd; end
            checks++;
            if (obs_unit() !== ex_u || issue_rd_o !== ex_rd) begin
                errors++; $display("FAIL reset_mid.issue k=%0d got unit=%0d rd=%0d want unit=%0d rd=%0d", k, obs_unit(), issue_rd_o, ex_u, ex_rd);
            end
            if (k == 2) begin
                checks++;
                if (fetch_accept_o !== 1'b0) begin
                    errors++; $display("FAIL reset_mid.accept got=%b want=0", fetch_accept_o);
                end
            end
            if (k == 3 || k == 5) begin
                checks++;
                if (busy_o !== 1'b0) begin
                    errors++; $display("FAIL reset_mid.busy k=%0d got=%b want=0", k, busy_o);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL reset_mid.drain left=%0d want=0", exp_q.size()); exp_q.delete();
        end
    endtask

    initial begin
        side_defaults();
        rst_i = 1'b1;
        test_reset();
        test_exec_stream();
        test_mul_dep();
        test_back_to_back();
        test_lsu();
        test_csr_div();
        test_priority();
        test_squash();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
